// File: rtl/tcdm_varlat_pkg.sv
// tcdm_varlat_pkg: shared response type, credit sizing and parameter limits for the TCDM bank adapter
package tcdm_varlat_pkg;
  localparam int unsigned MinMemLatency = 1;
  localparam int unsigned MinRespFifoDepth = 1;
  localparam int unsigned DefDataWidth = 32;
  typedef struct packed {
    logic [DefDataWidth-1:0] rdata;
  } resp_t;
  function automatic int unsigned credit_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/tcdm_varlat_resp_fifo.sv
// tcdm_varlat_resp_fifo: registered response FIFO with wrap-around pointers for any depth
module tcdm_varlat_resp_fifo #(
  parameter int unsigned Depth = 3,
  parameter int unsigned Width = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [Width-1:0]           data_i,
  output logic [Width-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth+1)-1:0] usage_o
);
  localparam int unsigned PW = Depth > 1 ? $clog2(Depth) : 1;
  localparam int unsigned UW = $clog2(Depth + 1);
  logic [Width-1:0] mem_q [Depth];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [UW-1:0] cnt_q;
  logic do_push, do_pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(Depth - 1) ? '0 : p + PW'(1);
  endfunction
  assign full_o = cnt_q == UW'(Depth);
  assign empty_o = cnt_q == '0;
  assign usage_o = cnt_q;
  assign do_push = push_i & ~full_o;
  assign do_pop = pop_i & ~empty_o;
  assign data_o = empty_o ? '0 : mem_q[rptr_q];
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
    end else begin
      wptr_q <= do_push ? nxt(wptr_q) : wptr_q;
      rptr_q <= do_pop ? nxt(rptr_q) : rptr_q;
      cnt_q <= cnt_q + UW'(do_push) - UW'(do_pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end
endmodule

// File: rtl/tcdm_varlat_bank_adapter.sv
// tcdm_varlat_bank_adapter: credit-bounded TCDM target responder driving a fixed-latency SRAM bank
// TCDM_VARLAT_WRITE_RESP_EN: when defined, writes also return a (zero-data) response and use a credit
module tcdm_varlat_bank_adapter
  import tcdm_varlat_pkg::*;
#(
  parameter int unsigned AddrWidth = 10,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned BeWidth = DataWidth / 8,
  parameter int unsigned MemLatency = 1,
  parameter int unsigned RespFifoDepth = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic [AddrWidth-1:0] add_i,
  input  logic                 we_i,
  input  logic [BeWidth-1:0]   be_i,
  input  logic [DataWidth-1:0] wdata_i,
  output logic                 vld_o,
  output logic [DataWidth-1:0] rdata_o,
  input  logic                 rsp_ready_i,
  output logic                 mem_req_o,
  input  logic                 mem_gnt_i,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_add_o,
  output logic [BeWidth-1:0]   mem_be_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  input  logic [DataWidth-1:0] mem_rdata_i
);
  localparam int unsigned CW = credit_width(RespFifoDepth);
  if (MemLatency < MinMemLatency) begin : g_bad_latency
    $error("MemLatency must be >= 1");
  end
  if (RespFifoDepth < MinRespFifoDepth) begin : g_bad_depth
    $error("RespFifoDepth must be >= 1");
  end
  logic responding, inc, pop, push, fifo_full, fifo_empty;
  logic [CW-1:0] credit_q, fifo_usage;
  logic [MemLatency-1:0] vld_q, wr_q;
  logic [DataWidth-1:0] push_data;
`ifdef TCDM_VARLAT_WRITE_RESP_EN
  assign responding = 1'b1;
`else
  assign responding = ~we_i;
`endif
  // Non-responding writes bypass the credit limit since they never occupy the FIFO
  assign gnt_o = rst_ni & req_i & mem_gnt_i & ((credit_q < CW'(RespFifoDepth)) | ~responding);
  assign mem_req_o = gnt_o;
  assign mem_we_o = we_i;
  assign mem_add_o = add_i;
  assign mem_be_o = be_i;
  assign mem_wdata_o = wdata_i;
  assign inc = gnt_o & responding;
  assign pop = vld_o & rsp_ready_i;
  assign push = vld_q[MemLatency-1];
  assign push_data = wr_q[MemLatency-1] ? '0 : mem_rdata_i;
  assign vld_o = ~fifo_empty;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_q <= '0;
      wr_q <= '0;
      credit_q <= '0;
    end else begin
      vld_q <= (vld_q << 1) | MemLatency'(inc);
      wr_q <= (wr_q << 1) | MemLatency'(we_i);
      credit_q <= inc & ~pop ? credit_q + CW'(1) : (pop & ~inc ? credit_q - CW'(1) : credit_q);
    end
  end
  tcdm_varlat_resp_fifo #(
    .Depth(RespFifoDepth),
    .Width(DataWidth)
  ) i_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (push),
    .pop_i  (pop),
    .data_i (push_data),
    .data_o (rdata_o),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .usage_o(fifo_usage)
  );
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && fifo_full))
    else $error("response FIFO push while full");
  assert property (@(posedge clk_i) disable iff (!rst_ni) credit_q >= fifo_usage)
    else $error("credit below FIFO occupancy");
endmodule
